// File: rtl/dsp_pkg.sv
// Shared types and constants for the DSP MAC stage: operand-select enumerations,
// default widths and the signed result limits used when saturating.
package dsp_pkg;

  localparam int AB_W_DEF = 18;
  localparam int P_W_DEF  = 48;

  localparam logic signed [P_W_DEF-1:0] P_MAX = {1'b0, {(P_W_DEF-1){1'b1}}};
  localparam logic signed [P_W_DEF-1:0] P_MIN = {1'b1, {(P_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    PRE_B     = 2'b00,
    PRE_DPB   = 2'b01,
    PRE_DMB   = 2'b10,
    PRE_B_ALT = 2'b11
  } pre_sel_e;

  typedef enum logic [1:0] {
    ACC_M   = 2'b00,
    ACC_PPM = 2'b01,
    ACC_CPM = 2'b10,
    ACC_PMM = 2'b11
  } acc_sel_e;

endpackage

// File: rtl/dsp_pre_adder.sv
// Combinational pre-adder: selects b, d + b or d - b at one bit of growth so
// the result is always exact.
module dsp_pre_adder
  import dsp_pkg::*;
#(
  parameter int AB_W = AB_W_DEF
) (
  input  logic signed [AB_W-1:0] b_i,
  input  logic signed [AB_W-1:0] d_i,
  input  pre_sel_e               sel_i,
  output logic signed [AB_W:0]   bp_o
);

  logic signed [AB_W:0] b_x;
  logic signed [AB_W:0] d_x;

  assign b_x = (AB_W+1)'(b_i);
  assign d_x = (AB_W+1)'(d_i);

  always_comb begin
    bp_o = b_x;
    case (sel_i)
      PRE_DPB: bp_o = d_x + b_x;
      PRE_DMB: bp_o = d_x - b_x;
      default: bp_o = b_x;
    endcase
  end

endmodule

// File: rtl/dsp_mac_stage.sv
// Pipelined multiply-accumulate stage: pre-adder, multiplier (optionally
// registered via PIPE_M) and post-adder with overflow detection. Defining the
// macro DSP_MAC_SAT_EN makes overflowing results saturate instead of wrap.
module dsp_mac_stage
  import dsp_pkg::*;
#(
  parameter int AB_W   = AB_W_DEF,
  parameter int P_W    = P_W_DEF,
  parameter int PIPE_M = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic signed [AB_W-1:0] a,
  input  logic signed [AB_W-1:0] b,
  input  logic signed [AB_W-1:0] d,
  input  logic signed [P_W-1:0]  c,
  input  logic [3:0]             opmode,
  output logic signed [P_W-1:0]  p,
  output logic                   out_valid,
  output logic                   ovf
);

  localparam int M_W = 2*AB_W + 1;

  function automatic logic signed [P_W-1:0] sat_f(input logic signed [P_W:0] s);
`ifdef DSP_MAC_SAT_EN
    if (s[P_W] != s[P_W-1])
      return s[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
`endif
    return s[P_W-1:0];
  endfunction

  pre_sel_e             pre_sel;
  logic signed [AB_W:0] bp;

  assign pre_sel = pre_sel_e'(opmode[1:0]);

  dsp_pre_adder #(.AB_W(AB_W)) u_pre_adder (
    .b_i   (b),
    .d_i   (d),
    .sel_i (pre_sel),
    .bp_o  (bp)
  );

  // Stage 1: operands, pre-adder result, addend and control
  logic signed [AB_W-1:0] a_p1_q;
  logic signed [AB_W:0]   bp_p1_q;
  logic signed [P_W-1:0]  c_p1_q;
  acc_sel_e               acc_p1_q;
  logic                   vld_p1_q;
  logic signed [M_W-1:0]  m_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p1_q   <= '0;
      bp_p1_q  <= '0;
      c_p1_q   <= '0;
      acc_p1_q <= ACC_M;
      vld_p1_q <= 1'b0;
    end else if (ce) begin
      a_p1_q   <= a;
      bp_p1_q  <= bp;
      c_p1_q   <= c;
      acc_p1_q <= acc_sel_e'(opmode[3:2]);
      vld_p1_q <= in_valid;
    end
  end

  assign m_p1 = M_W'(a_p1_q) * M_W'(bp_p1_q);

  // Stage M: product either registered or passed straight to the post-adder
  logic signed [M_W-1:0] m_f;
  logic signed [P_W-1:0] c_f;
  acc_sel_e              acc_f;
  logic                  vld_f;

  generate
    if (PIPE_M != 0) begin : g_pipe_m
      logic signed [M_W-1:0] m_p2_q;
      logic signed [P_W-1:0] c_p2_q;
      acc_sel_e              acc_p2_q;
      logic                  vld_p2_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          m_p2_q   <= '0;
          c_p2_q   <= '0;
          acc_p2_q <= ACC_M;
          vld_p2_q <= 1'b0;
        end else if (ce) begin
          m_p2_q   <= m_p1;
          c_p2_q   <= c_p1_q;
          acc_p2_q <= acc_p1_q;
          vld_p2_q <= vld_p1_q;
        end
      end

      assign m_f   = m_p2_q;
      assign c_f   = c_p2_q;
      assign acc_f = acc_p2_q;
      assign vld_f = vld_p2_q;
    end else begin : g_comb_m
      assign m_f   = m_p1;
      assign c_f   = c_p1_q;
      assign acc_f = acc_p1_q;
      assign vld_f = vld_p1_q;
    end
  endgenerate

  // Post-adder: one guard bit keeps the sum exact for overflow detection
  logic signed [P_W-1:0] p_q;
  logic                  ovf_q;
  logic                  out_valid_q;
  logic signed [P_W:0]   m_x;
  logic signed [P_W:0]   p_x;
  logic signed [P_W:0]   c_x;
  logic signed [P_W:0]   sum;
  logic signed [P_W-1:0] p_d;
  logic                  ovf_d;

  assign m_x = (P_W+1)'(m_f);
  assign p_x = (P_W+1)'(p_q);
  assign c_x = (P_W+1)'(c_f);

  always_comb begin
    sum = m_x;
    case (acc_f)
      ACC_PPM: sum = p_x + m_x;
      ACC_CPM: sum = c_x + m_x;
      ACC_PMM: sum = p_x - m_x;
      default: sum = m_x;
    endcase
  end

  assign ovf_d = sum[P_W] ^ sum[P_W-1];
  assign p_d   = sat_f(sum);

  // out_valid updates every edge so it drops as soon as a stall begins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= ce & vld_f;
      if (ce && vld_f) begin
        p_q   <= p_d;
        ovf_q <= ovf_d;
      end
    end
  end

  assign p         = p_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_dsp_mac_stage.sv
// Bench for dsp_mac_stage: directed scenarios plus randomized traffic scored
// against an arithmetic reference model of the MAC.
module tb_dsp_mac_stage;
  import dsp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic in_valid = 1'b0;
  logic signed [17:0] a = '0, b = '0, d = '0;
  logic signed [47:0] c = '0;
  logic [3:0] opmode = '0;
  logic signed [47:0] p, p0;
  logic out_valid, ovf, out_valid0, ovf0;

  always #5 clk = ~clk;

  dsp_mac_stage #(.AB_W(18), .P_W(48), .PIPE_M(1)) u_dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .d(d),
    .c(c), .opmode(opmode), .p(p), .out_valid(out_valid), .ovf(ovf));

  dsp_mac_stage #(.AB_W(18), .P_W(48), .PIPE_M(0)) u_dut0 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .d(d),
    .c(c), .opmode(opmode), .p(p0), .out_valid(out_valid0), .ovf(ovf0));

  int n_chk = 0, n_pass = 0, cyc = 0, vld_cyc = 0, vld0_cyc = 0, n_out = 0;
  int item_cyc, n0;
  longint mp = 0;
  longint qp[$];
  bit     qo[$];
  longint seen[$];
  longint pmax_l, pmin_l;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: full-precision arithmetic, then wrap or clamp to 48 bits.
  task automatic model_accept(input logic signed [17:0] ai, bi, di,
                              input logic signed [47:0] ci, input logic [3:0] op);
    longint av, bv, dv, cv, bp, m, ex, r;
    logic [47:0] w;
    bit o;
    av = ai; bv = bi; dv = di; cv = ci;
    case (op[1:0])
      2'b01:   bp = dv + bv;
      2'b10:   bp = dv - bv;
      default: bp = bv;
    endcase
    m = av * bp;
    case (op[3:2])
      2'b00:   ex = m;
      2'b01:   ex = mp + m;
      2'b10:   ex = cv + m;
      default: ex = mp - m;
    endcase
    o = (ex > pmax_l) || (ex < pmin_l);
    w = ex[47:0];
    r = longint'($signed(w));
`ifdef DSP_MAC_SAT_EN
    if (o) r = (ex > pmax_l) ? pmax_l : pmin_l;
`endif
    mp = r;
    qp.push_back(r);
    qo.push_back(o);
  endtask

  task automatic check_out();
    cyc++;
    if (out_valid0) vld0_cyc = cyc;
    if (out_valid) begin
      vld_cyc = cyc;
      n_out++;
      seen.push_back(longint'(p));
      if (qp.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        chk("p_model", p, qp.pop_front());
        chk("ovf_model", ovf, qo.pop_front());
      end
    end
  endtask

  task automatic drive(input logic v, input logic signed [17:0] ai, bi, di,
                       input logic signed [47:0] ci, input logic [3:0] op, input logic cei);
    in_valid = v; a = ai; b = bi; d = di; c = ci; opmode = op; ce = cei;
    @(posedge clk);
    if (cei && v) model_accept(ai, bi, di, ci, op);
    #1;
    check_out();
    if (!cei) chk("out_valid_stall", out_valid, 0);
  endtask

  task automatic bubble(input int n);
    repeat (n) drive(1'b0, 0, 0, 0, 0, 4'b0000, 1'b1);
  endtask

  initial begin
    logic [63:0] rnd;
    pmax_l = longint'(P_MAX);
    pmin_l = longint'(P_MIN);

    #12;
    chk("reset_p", p, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_p_pipe0", p0, 0);
    rst = 1'b0;
    ce = 1'b1;

    // Single item, latency through both pipeline depths
    vld_cyc = 0; vld0_cyc = 0;
    drive(1'b1, 3, 4, 0, 0, 4'b0000, 1'b1);
    item_cyc = cyc;
    bubble(4);
    chk("latency_pipe1", vld_cyc - item_cyc + 1, 3);
    chk("single_p", p, 12);
    chk("single_ovf", ovf, 0);
    chk("latency_pipe0", vld0_cyc - item_cyc + 1, 2);
    chk("single_p_pipe0", p0, 12);

    // Pre-adder subtract stream, then an accumulate with pre-adder add
    n0 = n_out;
    repeat (40) drive(1'b1, 5, 2, 10, 0, 4'b0010, 1'b1);
    bubble(4);
    chk("preadd_count", n_out - n0, 40);
    chk("preadd_p", p, 40);
    drive(1'b1, 1, 2, 10, 0, 4'b0101, 1'b1);
    bubble(4);
    chk("accum_p", p, 52);

    // Stall in the middle of an accumulate run
    seen.delete();
    drive(1'b1, 1, 1, 0, 0, 4'b0000, 1'b1);
    drive(1'b1, 1, 1, 0, 0, 4'b0100, 1'b1);
    repeat (4) drive(1'b1, 7, 7, 7, 0, 4'b0100, 1'b0);
    repeat (3) drive(1'b1, 1, 1, 0, 0, 4'b0100, 1'b1);
    bubble(4);
    chk("stall_count", seen.size(), 5);
    for (int i = 0; i < seen.size(); i++) chk("stall_seq", seen[i], i + 1);

    // Positive overflow of the accumulator
    seen.delete();
    drive(1'b1, 1, 1, 0, P_MAX - 48'sd1, 4'b1000, 1'b1);
    drive(1'b1, 1, 1, 0, 0, 4'b0100, 1'b1);
    bubble(4);
    chk("ovf_count", seen.size(), 2);
    chk("ovf_preload", seen[0], pmax_l);
`ifdef DSP_MAC_SAT_EN
    chk("ovf_p", p, pmax_l);
`else
    chk("ovf_p", p, pmin_l);
`endif
    chk("ovf_flag", ovf, 1);

    // Randomized traffic
    repeat (300) begin
      rnd = {$urandom(), $urandom()};
      drive($urandom_range(0, 3) != 0, 18'($urandom()), 18'($urandom()), 18'($urandom()),
            rnd[47:0], 4'($urandom()), $urandom_range(0, 4) != 0);
    end
    bubble(5);
    chk("random_drained", qp.size(), 0);

    // Asynchronous reset between edges with items in flight
    drive(1'b1, 2, 5, 0, 0, 4'b0000, 1'b1);
    drive(1'b1, 3, 3, 0, 0, 4'b0000, 1'b1);
    drive(1'b1, 4, 4, 0, 0, 4'b0000, 1'b1);
    chk("pre_reset_out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_p", p, 0);
    chk("async_out_valid", out_valid, 0);
    chk("async_ovf", ovf, 0);
    qp.delete(); qo.delete(); mp = 0;
    #1 rst = 1'b0;
    n0 = n_out;
    bubble(5);
    chk("flushed_no_output", n_out - n0, 0);
    vld_cyc = 0;
    drive(1'b1, 2, 3, 0, 0, 4'b0000, 1'b1);
    item_cyc = cyc;
    bubble(4);
    chk("post_reset_p", p, 6);
    chk("post_reset_latency", vld_cyc - item_cyc + 1, 3);
    chk("final_drained", qp.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
